// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath selects and ALU/op codes.
// Compare support (cmd 1010/1000 with S=1) is compiled in by the CMP_EN macro in controller.sv.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCA_A = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;

    localparam logic [1:0] SRCB_WD = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [1:0] OP_UNK = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/controller_condcheck.sv
// ARM condition-code evaluation against {N,Z,C,V}; purely combinational, zero latency.
// No handshake: result is consumed by the controller's CondExReg.
module condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic neg, zero, carry, ovf, ge;

    assign {neg, zero, carry, ovf} = flags;
    assign ge = (neg == ovf);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = zero;
            4'b0001: cond_ex = ~zero;
            4'b0010: cond_ex = carry;
            4'b0011: cond_ex = ~carry;
            4'b0100: cond_ex = neg;
            4'b0101: cond_ex = ~neg;
            4'b0110: cond_ex = ovf;
            4'b0111: cond_ex = ~ovf;
            4'b1000: cond_ex = carry & ~zero;
            4'b1001: cond_ex = ~carry | zero;
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~zero & ge;
            4'b1101: cond_ex = zero | ~ge;
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Multicycle ARM controller: ALU 4 cycles, LDR 5, STR 4, B 3, undefined op 3; no backpressure.
// Optional CMP_EN macro adds CMP/TST (flag-only, no register writeback).
module controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    state_t     state, state_nxt, cur;
    logic [3:0] flags;
    logic       cond_ex, cond_ex_reg;
    logic       reg_w, mem_w, branch, is_fetch;
    logic       dp_sup, dp_cv, dp_nowb;
    logic [2:0] dp_ctl;
    logic       in_exec;
    logic       unused_instr;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       imm_bit, s_bit, rd_pc;

    assign op = Instr[27:26];
    assign imm_bit = Instr[25];
    assign cmd = Instr[24:21];
    assign s_bit = Instr[20];
    assign rd_pc = (Instr[15:12] == 4'd15);
    assign unused_instr = ^Instr[11:0];

    condcheck u_condcheck (
        .cond    (Instr[31:28]),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // Data-processing decode; unsupported cmds still walk EXECUTE/ALUWB but write nothing.
    always_comb begin
        dp_sup = 1'b1;
        dp_ctl = ALU_ADD;
        dp_cv = 1'b0;
        dp_nowb = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_ctl = ALU_ADD; dp_cv = 1'b1; end
            CMD_SUB: begin dp_ctl = ALU_SUB; dp_cv = 1'b1; end
            CMD_AND: dp_ctl = ALU_AND;
            CMD_ORR: dp_ctl = ALU_ORR;
            CMD_EOR: dp_ctl = ALU_EOR;
`ifdef CMP_EN
            CMD_CMP: begin
                dp_sup = s_bit;
                dp_ctl = s_bit ? ALU_SUB : ALU_ADD;
                dp_cv = 1'b1;
                dp_nowb = 1'b1;
            end
            CMD_TST: begin
                dp_sup = s_bit;
                dp_ctl = s_bit ? ALU_AND : ALU_ADD;
                dp_nowb = 1'b1;
            end
`endif
            default: dp_sup = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  state_nxt = MEMADR;
                    OP_DP:   state_nxt = imm_bit ? EXECUTEI : EXECUTER;
                    OP_BR:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR:   state_nxt = s_bit ? MEMRD : MEMWR;
            MEMRD:    state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    assign in_exec = (state == EXECUTER) || (state == EXECUTEI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                cond_ex_reg <= cond_ex;
            if (in_exec && s_bit && cond_ex_reg && dp_sup) begin
                flags[3:2] <= ALUFlags[3:2];
                if (dp_cv)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Reset forces the FETCH decode so no stale strobe leaks out of an abandoned instruction.
    assign cur = reset ? FETCH : state;

    always_comb begin
        is_fetch = 1'b0;
        IRWrite = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        ResultSrc = RES_ALUOUT;
        ALUControl = ALU_ADD;
        reg_w = 1'b0;
        mem_w = 1'b0;
        branch = 1'b0;
        case (cur)
            FETCH: begin
                is_fetch = 1'b1;
                IRWrite = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMRD:    AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w = 1'b1;
            end
            EXECUTER: ALUControl = dp_ctl;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUControl = dp_ctl;
            end
            ALUWB:    reg_w = dp_sup & ~dp_nowb;
            BRANCH: begin
                ALUSrcB = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign RegWrite = reg_w & cond_ex_reg;
    assign MemWrite = mem_w & cond_ex_reg;
    assign PCWrite = is_fetch | (branch & cond_ex_reg) | (reg_w & cond_ex_reg & rd_pc);
    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign ImmSrc = op;

endmodule

// File: tb/tb_controller.sv
// Randomized bench for controller: per-instruction expected output sequence from an instruction-level model.
module tb_controller;

    logic        clk, reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    logic [3:0] mflags;
    logic [1:0] cur_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, Instr);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~b : b;
    endfunction

    // Returns {supported, writes_rd, updates_cv, alu_code}.
    function automatic logic [5:0] dp_info(input logic [3:0] cmd, input bit s);
        case (cmd)
            4'b0100: return {3'b111, 3'd0};
            4'b0010: return {3'b111, 3'd1};
            4'b0000: return {3'b110, 3'd2};
            4'b1100: return {3'b110, 3'd3};
            4'b0001: return {3'b110, 3'd4};
`ifdef CMP_EN
            4'b1010: return s ? {3'b101, 3'd1} : 6'd0;
            4'b1000: return s ? {3'b100, 3'd2} : 6'd0;
`endif
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [17:0] ex(input bit pcw, input bit memw, input bit regw, input bit irw,
                                       input bit adr, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [2:0] ctl);
        return {pcw, memw, regw, irw, adr, a, b, res, ctl, cur_op == 2'b01, cur_op == 2'b10, cur_op};
    endfunction

    task automatic cyc(input string tag, input logic [17:0] e, input logic [3:0] fl);
        ALUFlags = fl;
        @(negedge clk);
        check(tag, {14'b0, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                    ResultSrc, ALUControl, RegSrc, ImmSrc}, {14'b0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] efl);
        bit cok, rd15, wr;
        logic [5:0] di;
        Instr = ins;
        cur_op = ins[27:26];
        cok = cond_ok(ins[31:28], mflags);
        rd15 = (ins[15:12] == 4'd15);
        cyc("fetch", ex(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'($urandom));
        cyc("decode", ex(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'($urandom));
        case (cur_op)
            2'b01: begin
                cyc("memadr", ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'd0), 4'($urandom));
                if (ins[20]) begin
                    cyc("memrd", ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0), 4'($urandom));
                    cyc("memwb", ex(cok & rd15, 0, cok, 0, 0, 2'b00, 2'b00, 2'b01, 3'd0), 4'($urandom));
                end else begin
                    cyc("memwr", ex(0, cok, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0), 4'($urandom));
                end
            end
            2'b00: begin
                di = dp_info(ins[24:21], ins[20]);
                cyc("execute", ex(0, 0, 0, 0, 0, 2'b00, {1'b0, ins[25]}, 2'b00,
                                  di[5] ? di[2:0] : 3'd0), efl);
                if (di[5] && ins[20] && cok) begin
                    mflags[3:2] = efl[3:2];
                    if (di[3]) mflags[1:0] = efl[1:0];
                end
                wr = di[5] & di[4] & cok;
                cyc("aluwb", ex(wr & rd15, 0, wr, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0), 4'($urandom));
            end
            2'b10: cyc("branch", ex(cok, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0), 4'($urandom));
            default: cyc("unknown", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0), 4'($urandom));
        endcase
        check("flags", {28'b0, dut.flags}, {28'b0, mflags});
    endtask

    task automatic reset_mid_ldr();
        Instr = 32'hE590_4008;
        cur_op = 2'b01;
        cyc("rst_fetch", ex(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'hF);
        cyc("rst_decode", ex(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'hF);
        cyc("rst_memadr", ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'd0), 4'hF);
        reset = 1'b1;
        cyc("rst_in_memrd", ex(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'hF);
        reset = 1'b0;
        mflags = 4'b0000;
        check("rst_flags", {28'b0, dut.flags}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0] cmds [8];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b0000};
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[31:28] = 4'hE;
        if (r[27:26] == 2'b00) begin
            r[24:21] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 6)];
        end
        if ($urandom_range(0, 7) == 0) r[15:12] = 4'd15;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        Instr = 32'd0;
        ALUFlags = 4'd0;
        mflags = 4'd0;
        cur_op = 2'b00;
        @(posedge clk);
        #1;
        cyc("reset_outputs", ex(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0), 4'hF);
        check("reset_flags", {28'b0, dut.flags}, 32'd0);
        reset = 1'b0;

        run_instr(32'hE082_1003, 4'hF);   // ADD
        run_instr(32'hE590_4008, 4'hF);   // LDR
        run_instr(32'hE580_4008, 4'hF);   // STR
        run_instr(32'hE251_1001, 4'b0110); // SUBS -> Z set
        run_instr(32'h0A00_0002, 4'h0);   // BEQ taken
        run_instr(32'hE251_1001, 4'b0000); // SUBS -> Z clear
        run_instr(32'h0A00_0002, 4'h0);   // BEQ not taken
        run_instr(32'hE351_0000, 4'b0100); // CMP
        reset_mid_ldr();
        run_instr(32'hF082_1003, 4'hF);
        run_instr(32'hEC00_0000, 4'hF);
        run_instr(32'hE082_F003, 4'hF);   // ADD to PC

        for (int i = 0; i < 400; i++)
            run_instr(rand_instr(), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
